// File: rtl/core_memory_arbiter.sv
// rtl/core_memory_arbiter.sv - per-core arbiter for the shared memory bus port
//
// Purpose:
//   Shares one memory bus port between fetch (requester 0), load (1) and
//   store (2). One transaction is outstanding at a time. The granted request
//   is latched and stamped with bus ID {CORE_ID, requester index}. The
//   response, or a forced error response on timeout, is routed back to the
//   owner.
//
// Ports:
//   clk, rst_n                      core clock, asynchronous active-low reset
//   req_valid/req_ready             per-requester request handshake (ready is a one-cycle accept)
//   req_write/req_addr/req_wdata    per-requester request fields (slice i belongs to requester i)
//   rsp_valid/rsp_ready             per-requester response handshake
//   rsp_data/rsp_error              shared response payload and timeout flag
//   mem_req_*                       request channel towards the memory bus
//   mem_rsp_valid/id/data           response channel from the memory bus
//   id_mismatch                     sticky flag: a response with a foreign ID was seen
//
// Configuration:
//   ARB_FETCH_PRIORITY_EN  when defined, fetch wins whenever it is valid and
//                          loads/stores round-robin among themselves. When not
//                          defined, all requesters share one round-robin order.

module core_memory_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int ID_W           = 8,
  parameter int CORE_ID        = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_wdata,
  output logic [ID_W-1:0]           mem_req_id,
  input  logic                      mem_rsp_valid,
  input  logic [ID_W-1:0]           mem_rsp_id,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  output logic                      id_mismatch
);

  // The low two ID bits carry the requester index, the rest carry CORE_ID.
  localparam int                IDX_W    = 2;
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]   ID_BASE  = ID_W'(CORE_ID << IDX_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DELIVER
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     rr_last_q;
  logic [CNT_W-1:0]     tmo_cnt_q;
  logic                 mem_req_valid_q;
  logic                 mem_req_write_q;
  logic [ADDR_W-1:0]    mem_req_addr_q;
  logic [DATA_W-1:0]    mem_req_wdata_q;
  logic [ID_W-1:0]      mem_req_id_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 rsp_error_q;
  logic                 id_mismatch_q;

  logic                 win_any_d;
  logic [IDX_W-1:0]     win_idx_d;
  logic [IDX_W-1:0]     cand_d;
  logic [IDX_W-1:0]     rr_next_d;
  logic                 own_rsp_d;

  // Requester index 'step' positions after 'last' in the circular order.
  function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] last, input int step);
    return IDX_W'((int'(last) + step) % NUM_REQ);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Winner selection: first valid requester after the last one served.
  always_comb begin
    win_any_d = 1'b0;
    win_idx_d = '0;
    cand_d    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_d = rr_cand(rr_last_q, k);
      if (!win_any_d && req_valid[cand_d]) begin
        win_any_d = 1'b1;
        win_idx_d = cand_d;
      end
    end
`ifdef ARB_FETCH_PRIORITY_EN
    // Fetch overrides the rotation; rr_last never points at fetch, so the
    // rotation above only alternates loads and stores.
    if (req_valid[0]) begin
      win_any_d = 1'b1;
      win_idx_d = '0;
    end
`endif
  end

`ifdef ARB_FETCH_PRIORITY_EN
  assign rr_next_d = (grant_q == '0) ? rr_last_q : grant_q;
`else
  assign rr_next_d = grant_q;
`endif

  // The accept pulse is decoded from IDLE state so that the request is
  // latched in the same cycle it is acknowledged and mem_req_valid follows
  // one cycle later.
  assign req_ready = (state_q == S_IDLE && win_any_d) ? onehot(win_idx_d) : '0;

  assign own_rsp_d = mem_rsp_valid && (mem_rsp_id == mem_req_id_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      grant_q         <= '0;
      rr_last_q       <= IDX_W'(NUM_REQ - 1);
      tmo_cnt_q       <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_id_q    <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      rsp_error_q     <= 1'b0;
      id_mismatch_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_any_d) begin
            grant_q         <= win_idx_d;
            mem_req_write_q <= req_write[win_idx_d];
            mem_req_addr_q  <= req_addr[int'(win_idx_d)*ADDR_W +: ADDR_W];
            mem_req_wdata_q <= req_wdata[int'(win_idx_d)*DATA_W +: DATA_W];
            mem_req_id_q    <= ID_BASE | ID_W'(win_idx_d);
            mem_req_valid_q <= 1'b1;
            state_q         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Latched fields stay put until the bus takes them.
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            tmo_cnt_q       <= '0;
            state_q         <= S_WAIT_RSP;
          end
        end

        S_WAIT_RSP: begin
          if (own_rsp_d) begin
            // A matching response wins even in the final timeout cycle.
            rsp_data_q  <= mem_rsp_data;
            rsp_error_q <= 1'b0;
            rsp_valid_q <= onehot(grant_q);
            rr_last_q   <= rr_next_d;
            state_q     <= S_DELIVER;
          end else begin
            if (mem_rsp_valid) begin
              id_mismatch_q <= 1'b1;
            end
            if (tmo_cnt_q == CNT_LAST) begin
              rsp_data_q  <= '0;
              rsp_error_q <= 1'b1;
              rsp_valid_q <= onehot(grant_q);
              rr_last_q   <= rr_next_d;
              state_q     <= S_DELIVER;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
          end
        end

        S_DELIVER: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_id    = mem_req_id_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_error_q;
  assign id_mismatch   = id_mismatch_q;

endmodule
